pong_led_shifter: RTL and testbench
===================================

PONG_LED_SHIFTER -- requirements
Module: pong_led_shifter

Interface
REQ-001 Parameters: none; frame width fixed at 8 bits; divider width fixed at 32 bits.
REQ-002 _i_clk  input  1  single clock; all state changes on rising edge.
REQ-003 _i_rst  input  1  asynchronous, active-low reset; 0 = in reset.
REQ-004 _i_frame  input  8  LED frame from the pong game logic; bit 7 = leftmost LED.
REQ-005 _i_div  input  32  serial half-period in _i_clk cycles; 0 treated as 1.
REQ-006 __output  output  4  {busy[3], latch[2], sclk[1], sdata[0]} to external 74HC595-style shift register.

Function
REQ-007 State machine SHALL have states IDLE, SHIFT, LATCH.
REQ-008 Internal registers: shadow[7:0] (last frame sent), shreg[7:0], bitcnt[2:0], divcnt[31:0], dlat[31:0] (latched divider D), pending[0].
REQ-009 IDLE: on an edge where (_i_frame != shadow) or pending=1, SHALL load shreg and shadow from _i_frame, clear pending, latch D = max(_i_div,1), zero divcnt and bitcnt, enter SHIFT.
REQ-010 IDLE with no trigger: outputs all 0; state unchanged.
REQ-011 SHIFT: MSB first; sdata = shreg[7]; each bit has phase low (sclk=0, D cycles), then phase high (sclk=1, D cycles); shreg shifts left by 1 at end of each high phase.
REQ-012 After the high phase of bit 8 (bitcnt wrap 7->0), SHALL enter LATCH.
REQ-013 LATCH: latch=1, sclk=0, sdata=0 for D cycles, then return to IDLE.
REQ-014 busy=1 in SHIFT and LATCH; exactly 17*D cycles per transfer; busy=0 in IDLE.
REQ-015 Outputs are registered; the first SHIFT cycle (busy=1, sdata=bit7, sclk=0) is visible after the triggering edge.
REQ-016 _i_frame changes during SHIFT/LATCH SHALL NOT alter the transfer in progress; on return to IDLE the comparison re-evaluates and a new transfer starts at the next edge if the frame differs; intermediate values coalesce to the latest frame.
REQ-017 _i_div changes during a transfer SHALL be ignored until the next capture.
REQ-018 divcnt counts 0..D-1 per phase; D up to 2^32-1 SHALL NOT overflow (compare, not add-beyond).
REQ-019 The back-to-back gap between transfers SHALL be exactly one IDLE cycle.

Reset
REQ-020 While _i_rst=0, asynchronously: state=IDLE, __output=4'b0000, shadow=0x00, shreg=0x00, bitcnt=0, divcnt=0, dlat=1, pending=1.
REQ-021 Reset asserted mid-transfer SHALL abort immediately (no latch pulse); after release, pending forces retransmission of the current _i_frame.
REQ-022 First edge after release with pending=1 SHALL start a transfer even if _i_frame=0x00.

Verification
REQ-023 Reset release with _i_frame=0xA5, _i_div=3 -> one transfer, busy high 51 cycles; sdata per bit 1,0,1,0,0,1,0,1; sclk rises at transfer cycles 3,9,...,45; latch high cycles 48-50; then idle.
REQ-024 _i_div=0, frame 0x00->0xFF after initial transfer -> transfer with D=1, busy 17 cycles, sdata=1 for all 8 bits, latch 1 cycle.
REQ-025 _i_div=2, frame 0x01 starting transfer, change to 0x40 then 0x80 mid-transfer -> first transfer shifts 0x01 intact; exactly one further transfer of 0x80 starting after one IDLE cycle.
REQ-026 _i_frame held constant after a completed transfer for 200 cycles -> __output stays 4'b0000, no sclk edges.
REQ-027 _i_rst pulled low at transfer cycle 10 of frame 0x3C -> __output=0 immediately without clock; no latch pulse; after release, full 0x3C transfer re-sent.

Source files
------------

// File: rtl/pong_led_shifter.sv
// pong_led_shifter
//   Serialises the 8-bit pong LED frame into an external 74HC595-style shift
//   register whenever the frame changes (or after reset). Bits go out MSB first.
//   Each bit has a low sclk phase of D cycles and then a high sclk phase of D
//   cycles. A latch pulse of D cycles follows the eighth bit. D is the divider
//   value captured at the start of the transfer.
//
// Ports
//   _i_clk    : clock; all state changes on the rising edge
//   _i_rst    : asynchronous active-low reset
//   _i_frame  : LED frame, bit 7 = leftmost LED
//   _i_div    : serial half-period in clock cycles (0 behaves as 1)
//   __output  : registered {busy, latch, sclk, sdata}
module pong_led_shifter (
    input  logic        _i_clk,
    input  logic        _i_rst,
    input  logic [7:0]  _i_frame,
    input  logic [31:0] _i_div,
    output logic [3:0]  __output
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_LATCH = 2'd2;

    logic [1:0]  r_state;
    logic [7:0]  r_shadow;
    logic [7:0]  r_shreg;
    logic [2:0]  r_bitcnt;
    logic [31:0] r_divcnt;
    logic [31:0] r_dlat;
    logic        r_pending;
    logic [3:0]  r_out;

    logic        w_trigger;
    logic        w_phase_end;
    logic [31:0] w_div_eff;

    assign w_trigger   = (_i_frame != r_shadow) || r_pending;
    // r_dlat is never 0, so the subtraction cannot wrap; divcnt never passes
    // D-1, so a full-range divider cannot overflow the counter.
    assign w_phase_end = (r_divcnt == (r_dlat - 32'd1));
    assign w_div_eff   = (_i_div == '0) ? 32'd1 : _i_div;
    assign __output    = r_out;

    // r_out is computed from the next state so that the outputs are registered
    // and the first SHIFT cycle is visible right after the triggering edge.
    // r_out[1] doubles as the current sclk phase.
    always_ff @(posedge _i_clk or negedge _i_rst) begin
        if (!_i_rst) begin
            r_state   <= S_IDLE;
            r_shadow  <= '0;
            r_shreg   <= '0;
            r_bitcnt  <= '0;
            r_divcnt  <= '0;
            r_dlat    <= 32'd1;
            r_pending <= 1'b1;
            r_out     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_trigger) begin
                        r_shreg   <= _i_frame;
                        r_shadow  <= _i_frame;
                        r_pending <= 1'b0;
                        r_dlat    <= w_div_eff;
                        r_divcnt  <= '0;
                        r_bitcnt  <= '0;
                        r_state   <= S_SHIFT;
                        r_out     <= {1'b1, 1'b0, 1'b0, _i_frame[7]};
                    end else begin
                        r_out <= '0;
                    end
                end

                S_SHIFT: begin
                    if (w_phase_end) begin
                        r_divcnt <= '0;
                        if (!r_out[1]) begin
                            // low phase done: raise sclk on the same bit
                            r_out <= {1'b1, 1'b0, 1'b1, r_shreg[7]};
                        end else begin
                            // high phase done: advance to the next bit
                            r_shreg  <= {r_shreg[6:0], 1'b0};
                            r_bitcnt <= r_bitcnt + 3'd1;
                            if (r_bitcnt == 3'd7) begin
                                r_state <= S_LATCH;
                                r_out   <= 4'b1100;
                            end else begin
                                r_out <= {1'b1, 1'b0, 1'b0, r_shreg[6]};
                            end
                        end
                    end else begin
                        r_divcnt <= r_divcnt + 32'd1;
                    end
                end

                S_LATCH: begin
                    if (w_phase_end) begin
                        r_divcnt <= '0;
                        r_state  <= S_IDLE;
                        r_out    <= '0;
                    end else begin
                        r_divcnt <= r_divcnt + 32'd1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_out   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pong_led_shifter.sv
// tb_pong_led_shifter
//   Self-checking bench for pong_led_shifter. A transfer-level reference model
//   (transfer start time, captured frame and divider) predicts __output on
//   every cycle. Table-driven transfers, hand-written corner sequences and
//   randomized frame/divider/reset stimulus are all checked against it.
module tb_pong_led_shifter;

    logic        clk;
    logic        rst_n;
    logic [7:0]  frame;
    logic [31:0] div;
    logic [3:0]  dout;

    pong_led_shifter dut (
        ._i_clk   (clk),
        ._i_rst   (rst_n),
        ._i_frame (frame),
        ._i_div   (div),
        .__output (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: a transfer is "active" for 17*D cycles from its start.
    bit              m_active;
    longint unsigned m_t;
    longint unsigned m_D;
    logic [7:0]      m_F;
    logic [7:0]      m_shadow;
    bit              m_pending;

    function automatic void model_reset();
        m_active  = 0;
        m_t       = 0;
        m_D       = 1;
        m_F       = 8'h00;
        m_shadow  = 8'h00;
        m_pending = 1;
    endfunction

    function automatic void model_edge(input logic [7:0] f, input logic [31:0] d);
        if (m_active) begin
            m_t++;
            if (m_t >= 17 * m_D) m_active = 0;
        end else if (f != m_shadow || m_pending) begin
            m_active  = 1;
            m_t       = 0;
            m_F       = f;
            m_D       = (d == 0) ? 1 : longint'(d);
            m_shadow  = f;
            m_pending = 0;
        end
    endfunction

    function automatic logic [3:0] model_out();
        longint unsigned b;
        logic sclk;
        if (!m_active) return 4'b0000;
        if (m_t >= 16 * m_D) return 4'b1100;
        b    = m_t / (2 * m_D);
        sclk = (m_t % (2 * m_D)) >= m_D;
        return {1'b1, 1'b0, sclk, m_F[7 - b]};
    endfunction

    task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock: model advances on the edge, DUT compared 1 time unit later.
    task automatic step();
        @(posedge clk);
        if (rst_n) model_edge(frame, div);
        else       model_reset();
        #1;
        check4("cycle", dout, model_out());
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        model_reset();
        #1;
        check4("async_reset", dout, 4'b0000);
        for (int i = 0; i < cycles; i++) step();
        rst_n = 1'b1;
    endtask

    // Waits for busy, then observes one whole transfer. Frame changes may be
    // injected at given transfer cycles (-1 = none).
    task automatic run_transfer(input int ch1_t, input logic [7:0] ch1_v,
                                input int ch2_t, input logic [7:0] ch2_v,
                                output int waited, output int blen,
                                output logic [7:0] bits, output int nrise,
                                output int llen, output int frise);
        int t;
        logic prev;
        waited = 0; blen = 0; bits = 8'h00; nrise = 0; llen = 0; frise = -1;
        step();
        while (!dout[3] && waited < 8) begin
            waited++;
            step();
        end
        if (!dout[3]) begin
            check_int("busy_start_timeout", waited, 0);
            return;
        end
        t = 0;
        prev = 1'b0;
        while (dout[3] && t < 4000) begin
            blen++;
            if (dout[1] && !prev) begin
                bits = {bits[6:0], dout[0]};
                nrise++;
                if (frise < 0) frise = t;
            end
            prev = dout[1];
            if (dout[2]) llen++;
            if (t == ch1_t) frame = ch1_v;
            if (t == ch2_t) frame = ch2_v;
            t++;
            step();
        end
    endtask

    typedef struct {
        bit          rst;
        logic [7:0]  frame;
        logic [31:0] div;
        int          exp_busy;
        logic [7:0]  exp_bits;
        int          exp_latch;
        int          exp_first_rise;
    } vec_t;

    vec_t vecs[6];
    int waited, blen, nrise, llen, frise, nz;
    logic [7:0] bits;

    initial begin
        vecs[0] = '{1, 8'hA5, 32'd3, 51, 8'hA5, 3, 3};
        vecs[1] = '{0, 8'h00, 32'd1, 17, 8'h00, 1, 1};
        vecs[2] = '{0, 8'hFF, 32'd0, 17, 8'hFF, 1, 1};
        vecs[3] = '{0, 8'h3C, 32'd2, 34, 8'h3C, 2, 2};
        vecs[4] = '{0, 8'h81, 32'd5, 85, 8'h81, 5, 5};
        vecs[5] = '{1, 8'h00, 32'd2, 34, 8'h00, 2, 2};

        rst_n = 1'b0;
        frame = 8'hA5;
        div   = 32'd3;
        model_reset();

        for (int i = 0; i < $size(vecs); i++) begin
            frame = vecs[i].frame;
            div   = vecs[i].div;
            if (vecs[i].rst) do_reset(3);
            run_transfer(-1, 8'h00, -1, 8'h00, waited, blen, bits, nrise, llen, frise);
            check_int("tbl_wait", waited, 0);
            check_int("tbl_busy_len", blen, vecs[i].exp_busy);
            check_int("tbl_bits", int'(bits), int'(vecs[i].exp_bits));
            check_int("tbl_sclk_rises", nrise, 8);
            check_int("tbl_latch_len", llen, vecs[i].exp_latch);
            check_int("tbl_first_rise", frise, vecs[i].exp_first_rise);
        end

        // Frame changes mid-transfer coalesce into one follow-up transfer.
        frame = 8'h01;
        div   = 32'd2;
        run_transfer(10, 8'h40, 20, 8'h80, waited, blen, bits, nrise, llen, frise);
        check_int("coal_first_bits", int'(bits), 8'h01);
        check_int("coal_first_len", blen, 34);
        div = 32'd7;  // not captured until the next transfer starts
        run_transfer(-1, 8'h00, -1, 8'h00, waited, blen, bits, nrise, llen, frise);
        check_int("coal_gap_extra_idle", waited, 0);
        check_int("coal_second_bits", int'(bits), 8'h80);
        check_int("coal_second_len", blen, 17 * 7);

        // Constant frame: no activity for 200 cycles.
        nz = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (dout != 4'b0000) nz++;
        end
        check_int("idle_hold_activity", nz, 0);

        // Reset in the middle of a 0x3C transfer, then full retransmission.
        frame = 8'h3C;
        div   = 32'd3;
        nz = 0;
        step();
        for (int i = 0; i < 10; i++) begin
            step();
            if (dout[2]) nz++;
        end
        check_int("abort_busy_before", int'(dout[3]), 1);
        do_reset(2);
        check_int("abort_latch_seen", nz, 0);
        run_transfer(-1, 8'h00, -1, 8'h00, waited, blen, bits, nrise, llen, frise);
        check_int("resend_wait", waited, 0);
        check_int("resend_bits", int'(bits), 8'h3C);
        check_int("resend_len", blen, 51);
        check_int("resend_latch", llen, 3);

        // Randomized frames, dividers and occasional resets vs. the model.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 19) == 0) frame = 8'($urandom);
            if ($urandom_range(0, 49) == 0) div = $urandom_range(0, 4);
            if ($urandom_range(0, 399) == 0) do_reset($urandom_range(0, 2));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
